// File: rtl/fetch_pipe_reg.sv
// Fetch1 -> Fetch2 pipeline register: a two-entry (head + skid) FIFO holding
// whole fetch bundles, with registered ready_o and flush/zero-mask handling.
module fetch_pipe_reg #(
    parameter int FETCH_WIDTH = 4,
    parameter int SIZE_PC     = 32,
    parameter int INST_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic [SIZE_PC-1:0]              pc_i,
    input  logic [FETCH_WIDTH-1:0]          laneValid_i,
    input  logic [FETCH_WIDTH*INST_WIDTH-1:0] instBundle_i,
    input  logic [FETCH_WIDTH-1:0]          btbHit_i,
    input  logic [FETCH_WIDTH-1:0]          prediction_i,
    input  logic [FETCH_WIDTH*SIZE_PC-1:0]  targetAddr_i,
    output logic                            valid_o,
    output logic [SIZE_PC-1:0]              pc_o,
    output logic [FETCH_WIDTH-1:0]          laneValid_o,
    output logic [FETCH_WIDTH*INST_WIDTH-1:0] instBundle_o,
    output logic [FETCH_WIDTH-1:0]          btbHit_o,
    output logic [FETCH_WIDTH-1:0]          prediction_o,
    output logic [FETCH_WIDTH*SIZE_PC-1:0]  targetAddr_o,
    input  logic                            ready_i,
    output logic [1:0]                      occupancy_o
);

    typedef struct packed {
        logic [SIZE_PC-1:0]              pc;
        logic [FETCH_WIDTH-1:0]          lane_valid;
        logic [FETCH_WIDTH*INST_WIDTH-1:0] inst;
        logic [FETCH_WIDTH-1:0]          btb_hit;
        logic [FETCH_WIDTH-1:0]          prediction;
        logic [FETCH_WIDTH*SIZE_PC-1:0]  target;
    } entry_t;

    logic [1:0] occ_q, occ_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    entry_t     in_entry;
    logic       push, pop;

    assign in_entry = '{pc:         pc_i,
                        lane_valid: laneValid_i,
                        inst:       instBundle_i,
                        btb_hit:    btbHit_i,
                        prediction: prediction_i,
                        target:     targetAddr_i};

    // ready_o depends only on occ_q, so Fetch2's ready_i never reaches Fetch1.
    assign ready_o = (occ_q < 2'd2);
    assign valid_o = (occ_q != 2'd0);

    // Zero-mask bundles complete the handshake but are never stored.
    assign push = valid_i & ready_o & (|laneValid_i) & ~flush_i;
    assign pop  = valid_o & ready_i;

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch, so no path can infer a latch.
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        if (flush_i) begin
            occ_d  = 2'd0;
            head_d = '0;
            skid_d = '0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push) begin
                        head_d = in_entry;
                        occ_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = in_entry;
                    end else if (push) begin
                        skid_d = in_entry;
                        occ_d  = 2'd2;
                    end else if (pop) begin
                        head_d = '0;
                        occ_d  = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_d = skid_q;
                        skid_d = '0;
                        occ_d  = 2'd1;
                    end
                end
                default: begin
                    occ_d  = 2'd0;
                    head_d = '0;
                    skid_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: payload registers are reset as well as occupancy, because outputs read head_q directly and must be zero while valid_o is low.
        if (!reset) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    assign occupancy_o  = occ_q;
    assign pc_o         = head_q.pc;
    assign laneValid_o  = head_q.lane_valid;
    assign instBundle_o = head_q.inst;
    assign btbHit_o     = head_q.btb_hit;
    assign prediction_o = head_q.prediction;
    assign targetAddr_o = head_q.target;

endmodule

// File: tb/tb_fetch_pipe_reg.sv
// Bench for fetch_pipe_reg: four instances (FETCH_WIDTH 1/2/4/8) share stimulus
// and are checked every cycle against a bounded-queue reference model.
module tb_fetch_pipe_reg;

    localparam int NI = 4;

    typedef struct packed {
        logic [31:0]  pc;
        logic [7:0]   lv;
        logic [255:0] inst;
        logic [7:0]   btb;
        logic [7:0]   pred;
        logic [255:0] tgt;
    } tb_entry_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b0;
    logic [31:0]  pc_in = '0;
    logic [7:0]   lv_in = '0;
    logic [7:0]   btb_in = '0;
    logic [7:0]   pred_in = '0;
    logic [255:0] inst_in = '0;
    logic [255:0] tgt_in = '0;

    logic         o_ready [NI];
    logic         o_valid [NI];
    logic [1:0]   o_occ   [NI];
    logic [31:0]  o_pc    [NI];
    logic [7:0]   o_lv    [NI];
    logic [7:0]   o_btb   [NI];
    logic [7:0]   o_pred  [NI];
    logic [255:0] o_inst  [NI];
    logic [255:0] o_tgt   [NI];

    int n_checks = 0;
    int n_errors = 0;

    tb_entry_t mq [NI][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = 1 << g;
        logic           rdy, vld;
        logic [1:0]     occ;
        logic [31:0]    pc;
        logic [W-1:0]   lv, btb, pred;
        logic [W*32-1:0] inst, tgt;

        fetch_pipe_reg #(.FETCH_WIDTH(W), .SIZE_PC(32), .INST_WIDTH(32)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .flush_i      (flush_i),
            .valid_i      (valid_i),
            .ready_o      (rdy),
            .pc_i         (pc_in),
            .laneValid_i  (lv_in[W-1:0]),
            .instBundle_i (inst_in[W*32-1:0]),
            .btbHit_i     (btb_in[W-1:0]),
            .prediction_i (pred_in[W-1:0]),
            .targetAddr_i (tgt_in[W*32-1:0]),
            .valid_o      (vld),
            .pc_o         (pc),
            .laneValid_o  (lv),
            .instBundle_o (inst),
            .btbHit_o     (btb),
            .prediction_o (pred),
            .targetAddr_o (tgt),
            .ready_i      (ready_i),
            .occupancy_o  (occ)
        );

        assign o_ready[g] = rdy;
        assign o_valid[g] = vld;
        assign o_occ[g]   = occ;
        assign o_pc[g]    = pc;
        assign o_lv[g]    = 8'(lv);
        assign o_btb[g]   = 8'(btb);
        assign o_pred[g]  = 8'(pred);
        assign o_inst[g]  = 256'(inst);
        assign o_tgt[g]   = 256'(tgt);
    end

    // Current input bundle as instance i would store it (lanes beyond its width dropped).
    function automatic tb_entry_t slice_in(int i);
        int           w;
        logic [7:0]   lmask;
        logic [255:0] wmask;
        tb_entry_t    e;
        w     = 1 << i;
        lmask = 8'((1 << w) - 1);
        wmask = (256'(1) << (w * 32)) - 256'(1);
        e.pc   = pc_in;
        e.lv   = lv_in & lmask;
        e.inst = inst_in & wmask;
        e.btb  = btb_in & lmask;
        e.pred = pred_in & lmask;
        e.tgt  = tgt_in & wmask;
        return e;
    endfunction

    task automatic model_check();
        for (int i = 0; i < NI; i++) begin
            int        sz;
            tb_entry_t exp_e, obs_e;
            sz    = mq[i].size();
            exp_e = (sz != 0) ? mq[i][0] : '0;
            obs_e = '{pc: o_pc[i], lv: o_lv[i], inst: o_inst[i], btb: o_btb[i],
                      pred: o_pred[i], tgt: o_tgt[i]};
            n_checks += 3;
            if (o_valid[i] !== (sz != 0) || o_ready[i] !== (sz < 2)) begin
                n_errors++;
                $display("FAIL model_hs[w%0d] t=%0t: valid=%b ready=%b, want valid=%b ready=%b",
                         1 << i, $time, o_valid[i], o_ready[i], sz != 0, sz < 2);
            end
            if (o_occ[i] !== 2'(sz)) begin
                n_errors++;
                $display("FAIL model_occ[w%0d] t=%0t: occupancy=%0d, want %0d",
                         1 << i, $time, o_occ[i], sz);
            end
            if (obs_e !== exp_e) begin
                n_errors++;
                $display("FAIL model_head[w%0d] t=%0t: pc=%h lv=%h btb=%h pred=%h, want pc=%h lv=%h btb=%h pred=%h (inst/tgt match=%b/%b)",
                         1 << i, $time, obs_e.pc, obs_e.lv, obs_e.btb, obs_e.pred,
                         exp_e.pc, exp_e.lv, exp_e.btb, exp_e.pred,
                         obs_e.inst === exp_e.inst, obs_e.tgt === exp_e.tgt);
            end
        end
    endtask

    // Reference: bounded queue of capacity 2; accept when not full, pop when non-empty.
    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            int        sz;
            bit        do_pop, do_push;
            tb_entry_t e;
            sz = mq[i].size();
            e  = slice_in(i);
            if (!reset || flush_i) begin
                mq[i].delete();
            end else begin
                do_pop  = (sz != 0) && ready_i;
                do_push = valid_i && (sz < 2) && (e.lv != 8'd0);
                if (do_pop) void'(mq[i].pop_front());
                if (do_push) mq[i].push_back(e);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b0;
        lv_in = 8'hFF;
        pc_in = 32'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) mq[i].delete();
        n_checks++;
        if (o_occ[2] !== 2'd0 || o_valid[2] !== 1'b0 || o_ready[2] !== 1'b1 ||
            o_pc[2] !== 32'd0 || o_lv[2] !== 8'd0 || o_inst[2] !== '0) begin
            n_errors++;
            $display("FAIL reset_state: occ=%0d valid=%b ready=%b pc=%h lv=%h, want occ=0 valid=0 ready=1 pc=0 lv=0",
                     o_occ[2], o_valid[2], o_ready[2], o_pc[2], o_lv[2]);
        end
        valid_i = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h110; pcs[2] = 32'h120;
        ready_i = 1'b1;
        valid_i = 1'b1;
        lv_in = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            pc_in = pcs[k];
            cycle();
            n_checks++;
            if (o_pc[2] !== pcs[k] || o_occ[2] !== 2'd1 || o_ready[2] !== 1'b1 || o_valid[2] !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_%0d: pc=%h occ=%0d ready=%b valid=%b, want pc=%h occ=1 ready=1 valid=1",
                         k, o_pc[2], o_occ[2], o_ready[2], o_valid[2], pcs[k]);
            end
        end
        valid_i = 1'b0;
        cycle();
        n_checks++;
        if (o_valid[2] !== 1'b0 || o_pc[2] !== 32'd0 || o_occ[2] !== 2'd0) begin
            n_errors++;
            $display("FAIL stream_drain: valid=%b pc=%h occ=%0d, want valid=0 pc=0 occ=0",
                     o_valid[2], o_pc[2], o_occ[2]);
        end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        valid_i = 1'b1;
        lv_in = 8'hFF;
        pc_in = 32'h200;
        cycle();
        pc_in = 32'h210;
        cycle();
        n_checks++;
        if (o_occ[2] !== 2'd2 || o_ready[2] !== 1'b0 || o_pc[2] !== 32'h200) begin
            n_errors++;
            $display("FAIL bp_full: occ=%0d ready=%b pc=%h, want occ=2 ready=0 pc=200",
                     o_occ[2], o_ready[2], o_pc[2]);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        cycle();
        n_checks++;
        if (o_pc[2] !== 32'h210 || o_occ[2] !== 2'd1 || o_valid[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_skid_to_head: pc=%h occ=%0d valid=%b, want pc=210 occ=1 valid=1",
                     o_pc[2], o_occ[2], o_valid[2]);
        end
        cycle();
        n_checks++;
        if (o_valid[2] !== 1'b0 || o_occ[2] !== 2'd0) begin
            n_errors++;
            $display("FAIL bp_empty: valid=%b occ=%0d, want valid=0 occ=0", o_valid[2], o_occ[2]);
        end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        valid_i = 1'b1;
        lv_in = 8'hFF;
        pc_in = 32'h500;
        cycle();
        pc_in = 32'h510;
        cycle();
        flush_i = 1'b1;
        ready_i = 1'b1;
        pc_in = 32'h520;
        cycle();
        n_checks++;
        if (o_occ[2] !== 2'd0 || o_valid[2] !== 1'b0 || o_pc[2] !== 32'd0 || o_ready[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_load: occ=%0d valid=%b pc=%h ready=%b, want occ=0 valid=0 pc=0 ready=1",
                     o_occ[2], o_valid[2], o_pc[2], o_ready[2]);
        end
        flush_i = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic test_zero_mask();
        valid_i = 1'b1;
        ready_i = 1'b0;
        lv_in = 8'h00;
        pc_in = 32'h300;
        n_checks++;
        if (o_ready[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL zmask_ready: ready=%b, want 1", o_ready[2]);
        end
        cycle();
        n_checks++;
        if (o_occ[2] !== 2'd0 || o_valid[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL zmask_drop: occ=%0d valid=%b, want occ=0 valid=0", o_occ[2], o_valid[2]);
        end
        valid_i = 1'b0;
        lv_in = 8'hFF;
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        valid_i = 1'b1;
        lv_in = 8'hFF;
        pc_in = 32'h600;
        cycle();
        pc_in = 32'h610;
        cycle();
        reset = 1'b0;
        pc_in = 32'h620;
        cycle();
        n_checks++;
        if (o_occ[2] !== 2'd0 || o_valid[2] !== 1'b0 || o_ready[2] !== 1'b1 ||
            o_pc[2] !== 32'd0 || o_lv[2] !== 8'd0) begin
            n_errors++;
            $display("FAIL rst_mid: occ=%0d valid=%b ready=%b pc=%h lv=%h, want occ=0 valid=0 ready=1 pc=0 lv=0",
                     o_occ[2], o_valid[2], o_ready[2], o_pc[2], o_lv[2]);
        end
        reset = 1'b1;
        pc_in = 32'h400;
        cycle();
        n_checks++;
        if (o_valid[2] !== 1'b1 || o_pc[2] !== 32'h400 || o_occ[2] !== 2'd1) begin
            n_errors++;
            $display("FAIL rst_mid_push: valid=%b pc=%h occ=%0d, want valid=1 pc=400 occ=1",
                     o_valid[2], o_pc[2], o_occ[2]);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_random_sweep();
        for (int n = 0; n < 3000; n++) begin
            valid_i = ($urandom_range(0, 99) < 70);
            ready_i = ($urandom_range(0, 99) < 60);
            flush_i = ($urandom_range(0, 99) < 5);
            reset   = !($urandom_range(0, 199) < 2);
            lv_in   = ($urandom_range(0, 99) < 15) ? 8'h00 : 8'($urandom);
            btb_in  = 8'($urandom);
            pred_in = 8'($urandom);
            pc_in   = $urandom;
            for (int k = 0; k < 8; k++) begin
                inst_in[k*32 +: 32] = $urandom;
                tgt_in[k*32 +: 32]  = $urandom;
            end
            cycle();
        end
        reset = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) cycle();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_zero_mask();
        test_reset_mid();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_pipe_reg.md
FETCH_PIPE_REG -- requirements
Module: fetch_pipe_reg

Interface
REQ-001 Parameter FETCH_WIDTH, default 4: number of instruction lanes per fetch bundle.
REQ-002 Parameter SIZE_PC, default 32: PC and branch-target width in bits.
REQ-003 Parameter INST_WIDTH, default 32: width of one instruction slot in bits.
REQ-004 Port clk  in  1  single clock for all state; all state updates on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-low reset (0 = reset asserted).
REQ-006 Port flush_i  in  1  synchronous kill of all buffered bundles.
REQ-007 Port valid_i  in  1  upstream (Fetch1) offers a bundle.
REQ-008 Port ready_o  out  1  block can accept a bundle this cycle.
REQ-009 Port pc_i  in  SIZE_PC  bundle PC.
REQ-010 Port laneValid_i  in  FETCH_WIDTH  per-lane valid mask.
REQ-011 Port instBundle_i  in  FETCH_WIDTH*INST_WIDTH  instructions; lane k occupies bits [k*INST_WIDTH +: INST_WIDTH].
REQ-012 Port btbHit_i / prediction_i  in  FETCH_WIDTH each  per-lane BTB hit and direction prediction.
REQ-013 Port targetAddr_i  in  FETCH_WIDTH*SIZE_PC  per-lane predicted target, packed like instBundle_i.
REQ-014 Ports valid_o, pc_o, laneValid_o, instBundle_o, btbHit_o, prediction_o, targetAddr_o  out  widths mirror the inputs  head bundle toward Fetch2.
REQ-015 Port ready_i  in  1  downstream (Fetch2) accepts the head bundle.
REQ-016 Port occupancy_o  out  2  number of buffered bundles (0..2).

Function
REQ-017 Storage: two-entry FIFO, entries head and skid; each entry holds all payload fields.
REQ-018 Push = valid_i & ready_o & (|laneValid_i) & ~flush_i; pop = valid_o & ready_i.
REQ-019 Bundles with laneValid_i == 0 are handshaken (consumed) but not stored.
REQ-020 ready_o = (occupancy < 2), driven from registered state only, with no combinational path from ready_i.
REQ-021 valid_o = (occupancy != 0); payload outputs are driven directly from head-entry registers.
REQ-022 Latency: a bundle pushed at edge N appears on valid_o/payload after edge N when the FIFO was empty.
REQ-023 Occupancy 0, push: head <= input; occupancy 1.
REQ-024 Occupancy 1, push and no pop: skid <= input; occupancy 2.
REQ-025 Occupancy 1, push and pop simultaneously: head <= input; occupancy stays 1.
REQ-026 Occupancy 1, pop only: occupancy 0; head payload cleared to zero.
REQ-027 Occupancy 2, pop: head <= skid; skid cleared; occupancy 1. No push is possible at occupancy 2 because ready_o = 0.
REQ-028 Occupancy 2, no pop: all state held; upstream sees ready_o = 0.
REQ-029 Order: bundles leave in acceptance order; none are duplicated or lost, except zero-mask drops (REQ-019) and flush (REQ-030).
REQ-030 flush_i = 1 at an edge: occupancy <= 0 and all payload registers <= 0, regardless of valid_i or ready_i in that cycle; flush wins over a simultaneous push or pop.
REQ-031 The pop handshake in the flush cycle is still seen by Fetch2; Fetch2 is responsible for discarding on flush.
REQ-032 Whenever valid_o = 0, all payload outputs are zero.

Reset
REQ-033 reset = 0 at an edge: occupancy_o = 0, valid_o = 0, ready_o = 1, and all payload outputs = 0.
REQ-034 reset has priority over flush_i, push, and pop.
REQ-035 reset asserted mid-operation discards all buffered bundles within one edge.
REQ-036 Outputs are undefined before the first reset edge; the bench holds reset low for at least 2 cycles.

Verification
REQ-037 Streaming: ready_i = 1, valid_i = 1, pc_i = 0x100, 0x110, 0x120 on consecutive cycles -> pc_o = 0x100, 0x110, 0x120 one cycle later, occupancy_o = 1, ready_o stays 1.
REQ-038 Backpressure: ready_i = 0, push 0x200 then 0x210 -> occupancy_o = 2, ready_o = 0, pc_o = 0x200; raise ready_i -> pc_o = 0x210 next cycle, then valid_o = 0.
REQ-039 Flush under load: occupancy 2 with flush_i = 1 and valid_i = 1 in the same cycle -> next cycle occupancy_o = 0, valid_o = 0, pc_o = 0, ready_o = 1.
REQ-040 Zero mask: valid_i = 1, laneValid_i = 4'b0000, pc_i = 0x300 -> ready_o = 1, occupancy_o stays 0, valid_o stays 0.
REQ-041 Reset mid-operation: occupancy 2, reset = 0 for one edge -> all outputs at the REQ-033 values; a push on the following cycle appears with 1-cycle latency.
REQ-042 Parameter sweep: FETCH_WIDTH = 1, 2, 4, 8 with random valid_i/ready_i/flush_i against a reference queue model -> no order, duplication, or loss mismatch.
